// File: rtl/conv_writeback_pkg.sv
// Shared definitions for the convolution writeback stage: default widths,
// FSM state encoding and debug-visible state type.
package conv_writeback_pkg;

  localparam int DEF_ACC_W  = 20;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DIM_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCEPT = 3'd1,
    ST_WR0    = 3'd2,
    ST_WR1    = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/conv_writeback_requant_sat.sv
// Combinational requantizer: round-half-up arithmetic right shift, then clamp
// to the unsigned (ReLU) or signed DATA_W range.
module requant_sat #(
  parameter int ACC_W  = 20,
  parameter int DATA_W = 8
) (
  input  logic signed [ACC_W-1:0]  i_sum,
  input  logic        [3:0]        i_shift,
  input  logic                     i_relu_en,
  output logic        [DATA_W-1:0] o_data
);

  // One extra bit keeps the rounding add from overflowing at the positive limit.
  localparam int W = ACC_W + 1;

  localparam logic signed [W-1:0] LIM_U_MAX = W'((2 ** DATA_W) - 1);
  localparam logic signed [W-1:0] LIM_S_MAX = W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [W-1:0] LIM_S_MIN = W'(-(2 ** (DATA_W - 1)));

  logic signed [W-1:0] w_ext;
  logic signed [W-1:0] w_rnd;
  logic signed [W-1:0] w_sum;
  logic signed [W-1:0] w_shr;

  assign w_ext = {i_sum[ACC_W-1], i_sum};
  assign w_rnd = (i_shift == 4'd0) ? '0 : (W'(1) << (i_shift - 4'd1));
  assign w_sum = w_ext + w_rnd;
  assign w_shr = w_sum >>> i_shift;

  always_comb begin
    o_data = w_shr[DATA_W-1:0];
    if (i_relu_en) begin
      if (w_shr < 0)              o_data = '0;
      else if (w_shr > LIM_U_MAX) o_data = LIM_U_MAX[DATA_W-1:0];
    end else begin
      if (w_shr > LIM_S_MAX)      o_data = LIM_S_MAX[DATA_W-1:0];
      else if (w_shr < LIM_S_MIN) o_data = LIM_S_MIN[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/conv_writeback.sv
// Writeback stage: accepts accumulator pairs, requantizes each sum to a pixel
// and writes the pixels row-major into the output feature-map memory.
module conv_writeback
  import conv_writeback_pkg::*;
#(
  parameter int ACC_W  = DEF_ACC_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DIM_W  = DEF_DIM_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_dst_base,
  input  logic [DIM_W-1:0]  i_out_w,
  input  logic [DIM_W-1:0]  i_out_h,
  input  logic [3:0]        i_shift,
  input  logic              i_relu_en,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [ACC_W-1:0]  i_sum0,
  input  logic [ACC_W-1:0]  i_sum1,
  input  logic              i_sum1_vld,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_ovf,
  output state_t            o_dbg_state
);

  // Handshake: a pair transfers on a rising edge where i_valid & o_ready; o_ready
  // depends only on state, and the producer holds data stable until it transfers.

  state_t             r_state, w_next_state;
  logic [ADDR_W-1:0]  r_ptr;
  logic [DIM_W-1:0]   r_col, r_row, r_out_w, r_out_h;
  logic [3:0]         r_shift;
  logic               r_relu;
  logic [ACC_W-1:0]   r_sum0, r_sum1;
  logic               r_sum1_vld;
  logic               r_ovf;

  logic               w_we, w_ready, w_done, w_sel_sum1, w_last;
  logic [ACC_W-1:0]   w_sel_sum;
  logic [DATA_W-1:0]  w_pix;

  assign w_last    = (r_row == r_out_h - 1'b1) && (r_col == r_out_w - 1'b1);
  assign w_sel_sum = w_sel_sum1 ? r_sum1 : r_sum0;

  requant_sat #(
    .ACC_W  (ACC_W),
    .DATA_W (DATA_W)
  ) u_requant (
    .i_sum     (w_sel_sum),
    .i_shift   (r_shift),
    .i_relu_en (r_relu),
    .o_data    (w_pix)
  );

  always_comb begin
    w_next_state = r_state;
    w_we         = 1'b0;
    w_ready      = 1'b0;
    w_done       = 1'b0;
    w_sel_sum1   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) w_next_state = ST_ACCEPT;
      end
      ST_ACCEPT: begin
        w_ready = 1'b1;
        if (i_valid) w_next_state = ST_WR0;
      end
      ST_WR0: begin
        w_we = 1'b1;
        if (w_last)          w_next_state = ST_DONE;
        else if (r_sum1_vld) w_next_state = ST_WR1;
        else                 w_next_state = ST_ACCEPT;
      end
      ST_WR1: begin
        w_we       = 1'b1;
        w_sel_sum1 = 1'b1;
        w_next_state = w_last ? ST_DONE : ST_ACCEPT;
      end
      ST_DONE: begin
        w_done       = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_ptr      <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_out_w    <= '0;
      r_out_h    <= '0;
      r_shift    <= '0;
      r_relu     <= 1'b0;
      r_sum0     <= '0;
      r_sum1     <= '0;
      r_sum1_vld <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && i_start) begin
        r_ptr   <= i_dst_base;
        r_col   <= '0;
        r_row   <= '0;
        r_out_w <= i_out_w;
        r_out_h <= i_out_h;
        r_shift <= i_shift;
        r_relu  <= i_relu_en;
        r_ovf   <= 1'b0;
      end
      if (w_ready && i_valid) begin
        r_sum0     <= i_sum0;
        r_sum1     <= i_sum1;
        r_sum1_vld <= i_sum1_vld;
      end
      if (w_we) begin
        r_ptr <= r_ptr + 1'b1;
        if (r_col == r_out_w - 1'b1) begin
          r_col <= '0;
          r_row <= r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
      // A second pixel arriving with the map's final pixel has nowhere to go.
      if (r_state == ST_WR0 && w_last && r_sum1_vld) r_ovf <= 1'b1;
    end
  end

  assign o_ready     = w_ready;
  assign o_mem_we    = w_we;
  assign o_mem_addr  = w_we ? r_ptr : '0;
  assign o_mem_wdata = w_we ? w_pix : '0;
  assign o_busy      = (r_state != ST_IDLE);
  assign o_done      = w_done;
  assign o_ovf       = r_ovf;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_conv_writeback.sv
// Directed bench for conv_writeback: drivers push expected writes into a
// queue, a negedge monitor pops and compares every memory write and done pulse.
module tb_conv_writeback;

  logic        i_clk, i_rst, i_start, i_relu_en, i_valid, i_sum1_vld;
  logic [15:0] i_dst_base;
  logic [7:0]  i_out_w, i_out_h;
  logic [3:0]  i_shift;
  logic [19:0] i_sum0, i_sum1;
  logic        o_ready, o_mem_we, o_busy, o_done, o_ovf;
  logic [15:0] o_mem_addr;
  logic [7:0]  o_mem_wdata;
  conv_writeback_pkg::state_t o_dbg_state;

  conv_writeback dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .i_dst_base  (i_dst_base),
    .i_out_w     (i_out_w),
    .i_out_h     (i_out_h),
    .i_shift     (i_shift),
    .i_relu_en   (i_relu_en),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_sum0      (i_sum0),
    .i_sum1      (i_sum1),
    .i_sum1_vld  (i_sum1_vld),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_ovf       (o_ovf),
    .o_dbg_state (o_dbg_state)
  );

  // clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int done_base = 0;
  int last_we = -10;
  logic [23:0] exp_q[$];
  logic [15:0] exp_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // scoreboard monitor
  always @(negedge i_clk) begin
    logic [23:0] exp;
    if (o_mem_we) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h with nothing expected",
                 o_mem_addr, o_mem_wdata);
      end else begin
        exp = exp_q.pop_front();
        if ({o_mem_addr, o_mem_wdata} !== exp) begin
          n_fail++;
          $display("FAIL write: got addr 0x%0h data 0x%0h expected addr 0x%0h data 0x%0h",
                   o_mem_addr, o_mem_wdata, exp[23:8], exp[7:0]);
        end
      end
      check("ready_during_write", {31'd0, o_ready}, 32'd0);
      last_we = cyc;
    end
    if (o_done) begin
      check("done_latency", cyc - last_we, 32'd1);
      check("done_queue_empty", exp_q.size(), 32'd0);
      done_cnt++;
    end
  end

  // driver tasks
  task automatic start_map(input logic [15:0] base, input logic [7:0] w, input logic [7:0] h,
                           input logic [3:0] sh, input logic relu);
    i_dst_base = base;
    i_out_w    = w;
    i_out_h    = h;
    i_shift    = sh;
    i_relu_en  = relu;
    exp_addr   = base;
    done_base  = done_cnt;
    i_start    = 1'b1;
    @(posedge i_clk); #1;
    i_start    = 1'b0;
    check("busy_after_start", {31'd0, o_busy}, 32'd1);
  endtask

  task automatic push_px(input logic [7:0] d);
    exp_q.push_back({exp_addr, d});
    exp_addr = exp_addr + 16'd1;
  endtask

  task automatic send_pair(input logic [19:0] s0, input logic [19:0] s1, input logic v1,
                           input logic [7:0] e0, input logic [7:0] e1, input logic w1,
                           input int gap);
    int t;
    repeat (gap) begin @(posedge i_clk); #1; end
    i_sum0 = s0;
    i_sum1 = s1;
    i_sum1_vld = v1;
    push_px(e0);
    if (w1) push_px(e1);
    i_valid = 1'b1;
    t = 0;
    while (!o_ready && t < 20) begin
      @(posedge i_clk); #1;
      t++;
    end
    check("ready_timeout", {31'd0, o_ready}, 32'd1);
    @(posedge i_clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while (done_cnt == done_base && t < 60) begin
      @(posedge i_clk); #1;
      t++;
    end
    n_chk++;
    if (done_cnt == done_base) begin
      n_fail++;
      $display("FAIL %s: done not seen within %0d cycles", name, t);
    end
    check({name, "_idle"}, {31'd0, o_busy}, 32'd0);
  endtask

  initial begin
    i_rst = 1'b0; i_start = 1'b0; i_valid = 1'b0; i_sum1_vld = 1'b0;
    i_dst_base = '0; i_out_w = '0; i_out_h = '0; i_shift = '0; i_relu_en = 1'b0;
    i_sum0 = '0; i_sum1 = '0;
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_ready", {31'd0, o_ready}, 32'd0);
    check("rst_we", {31'd0, o_mem_we}, 32'd0);
    check("rst_addr", {16'd0, o_mem_addr}, 32'd0);
    check("rst_wdata", {24'd0, o_mem_wdata}, 32'd0);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    check("rst_done", {31'd0, o_done}, 32'd0);
    check("rst_ovf", {31'd0, o_ovf}, 32'd0);
    i_rst = 1'b1;
    @(posedge i_clk); #1;

    // 1: relu clamp, shift 0
    start_map(16'h0100, 8'd4, 8'd1, 4'd0, 1'b1);
    send_pair(20'd5, 20'd7, 1'b1, 8'd5, 8'd7, 1'b1, 0);
    send_pair(20'd300, -20'sd3, 1'b1, 8'd255, 8'd0, 1'b1, 0);
    wait_done("t1");
    check("t1_ovf", {31'd0, o_ovf}, 32'd0);

    // 2: rounding shift, signed saturation
    start_map(16'h0200, 8'd4, 8'd1, 4'd4, 1'b0);
    send_pair(20'd24, -20'sd24, 1'b1, 8'h02, 8'hFF, 1'b1, 1);
    send_pair(20'd2047, -20'sd4000, 1'b1, 8'h7F, 8'h80, 1'b1, 2);
    wait_done("t2");

    // 3: 3x2 map, odd row tails, address wrap, i_start while busy ignored
    start_map(16'hFFFE, 8'd3, 8'd2, 4'd0, 1'b0);
    send_pair(20'd10, -20'sd5, 1'b1, 8'h0A, 8'hFB, 1'b1, 0);
    i_dst_base = 16'h0000; i_out_w = 8'd1; i_out_h = 8'd1; i_relu_en = 1'b1;
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    send_pair(20'd30, 20'd0, 1'b0, 8'h1E, 8'h00, 1'b0, 0);
    send_pair(20'd40, 20'd200, 1'b1, 8'h28, 8'h7F, 1'b1, 1);
    send_pair(-20'sd200, 20'd0, 1'b0, 8'h80, 8'h00, 1'b0, 0);
    wait_done("t3");
    check("t3_ovf", {31'd0, o_ovf}, 32'd0);

    // 4: 1x1 map with a surplus pixel
    start_map(16'h0050, 8'd1, 8'd1, 4'd0, 1'b1);
    send_pair(20'd9, 20'd9, 1'b1, 8'd9, 8'd0, 1'b0, 0);
    wait_done("t4");
    check("t4_ovf_set", {31'd0, o_ovf}, 32'd1);

    // 5: random gaps, rounding with shift 1; start clears ovf
    start_map(16'h0300, 8'd4, 8'd2, 4'd1, 1'b1);
    check("t5_ovf_cleared", {31'd0, o_ovf}, 32'd0);
    send_pair(20'd3, 20'd4, 1'b1, 8'd2, 8'd2, 1'b1, $urandom_range(0, 3));
    send_pair(-20'sd3, 20'd1000, 1'b1, 8'd0, 8'd255, 1'b1, $urandom_range(0, 3));
    send_pair(20'd7, 20'd8, 1'b1, 8'd4, 8'd4, 1'b1, $urandom_range(0, 3));
    send_pair(20'd510, 20'd511, 1'b1, 8'd255, 8'd255, 1'b1, $urandom_range(0, 3));
    wait_done("t5");

    // 6: reset during WR0
    start_map(16'h0400, 8'd2, 8'd1, 4'd0, 1'b1);
    i_sum0 = 20'd1; i_sum1 = 20'd2; i_sum1_vld = 1'b1; i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    check("t6_we_in_wr0", {31'd0, o_mem_we}, 32'd1);
    check("t6_addr_in_wr0", {16'd0, o_mem_addr}, 32'h0400);
    #1 i_rst = 1'b0;
    #1;
    check("t6_rst_we", {31'd0, o_mem_we}, 32'd0);
    check("t6_rst_addr", {16'd0, o_mem_addr}, 32'd0);
    check("t6_rst_wdata", {24'd0, o_mem_wdata}, 32'd0);
    check("t6_rst_busy", {31'd0, o_busy}, 32'd0);
    check("t6_rst_ready", {31'd0, o_ready}, 32'd0);
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    check("t6_idle_after_rst", {31'd0, o_busy}, 32'd0);
    start_map(16'h0010, 8'd2, 8'd1, 4'd0, 1'b0);
    send_pair(20'd1, 20'd2, 1'b1, 8'd1, 8'd2, 1'b1, 0);
    wait_done("t6_recover");

    repeat (3) @(posedge i_clk);
    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
